// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Bit positions inside the first byte of a movement packet
    localparam int unsigned BTN_L    = 0;
    localparam int unsigned BTN_R    = 1;
    localparam int unsigned BTN_M    = 2;
    localparam int unsigned SYNC_BIT = 3;
    localparam int unsigned X_SIGN   = 4;
    localparam int unsigned Y_SIGN   = 5;
    localparam int unsigned X_OVF    = 6;
    localparam int unsigned Y_OVF    = 7;

    typedef struct packed {
        logic [2:0] buttons;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       x_ovf;
        logic       y_ovf;
    } mouse_pkt_t;

    // Saturate a signed coordinate into [0, hi]
    function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                               input logic [9:0] hi);
        if (v < 0) begin
            return '0;
        end else if (v > $signed({1'b0, hi})) begin
            return hi;
        end else begin
            return v[9:0];
        end
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: line synchronisers, falling-edge detect,
// start/data/parity/stop framing and inactivity timeout. Shared by mouse and keyboard.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       hold,        // caller is mid-message; keep the timeout armed
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       timeout
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             busy;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    // Reset to 1 (idle bus level) so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall      = clk_prev_q & ~clk_sync_q;
    assign byte_data = shift_q;

    // Frame FSM and timeout state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Next-state, byte strobes and timeout; an edge in the same cycle beats the timeout
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;

        busy    = (state_q != StIdle) || hold;
        timeout = busy && !fall && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC));

        if (fall || !busy || timeout) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (timeout) begin
            state_d  = StIdle;
            byte_err = (state_q != StIdle);
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_sync_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_sync_q;
                    state_d = StStop;
                end
                StStop: begin
                    // Odd parity: XOR over data and parity bit must be 1
                    if (data_sync_q && (^{shift_q, par_q})) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: assembles 3-byte movement packets from ps2_rx_byte.
// Optional cursor tracking is enabled by defining MOUSE_CURSOR_EN.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
`ifdef MOUSE_CURSOR_EN
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
`endif
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       timeout;

    logic [1:0] idx_q, idx_d;
    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;
    mouse_pkt_t pkt_q, pkt_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       frame_err_q, frame_err_d;

    ps2_rx_byte #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .hold       (idx_q != 2'd0),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .timeout    (timeout)
    );

    // Packet assembler state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pkt_q       <= '0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            pkt_q       <= pkt_d;
            pkt_valid_q <= pkt_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte sequencing; a first byte without the sync bit is dropped to resynchronise
    always_comb begin
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        pkt_d       = pkt_q;
        pkt_valid_d = 1'b0;
        frame_err_d = byte_err;

        if (byte_err || timeout) begin
            idx_d = 2'd0;
        end else if (byte_valid) begin
            unique case (idx_q)
                2'd0: begin
                    if (byte_data[SYNC_BIT]) begin
                        b0_d  = byte_data;
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = byte_data;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    pkt_d.buttons = {b0_q[BTN_M], b0_q[BTN_R], b0_q[BTN_L]};
                    pkt_d.dx      = {b0_q[X_SIGN], b1_q};
                    pkt_d.dy      = {b0_q[Y_SIGN], byte_data};
                    pkt_d.x_ovf   = b0_q[X_OVF];
                    pkt_d.y_ovf   = b0_q[Y_OVF];
                    pkt_valid_d   = 1'b1;
                    idx_d         = 2'd0;
                end
                default: idx_d = 2'd0;
            endcase
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign frame_err = frame_err_q;
    assign buttons   = pkt_q.buttons;
    assign dx        = pkt_q.dx;
    assign dy        = pkt_q.dy;
    assign x_ovf     = pkt_q.x_ovf;
    assign y_ovf     = pkt_q.y_ovf;

`ifdef MOUSE_CURSOR_EN
    localparam logic [9:0] X_CENTER = 10'(SCREEN_W / 2);
    localparam logic [9:0] Y_CENTER = 10'(SCREEN_H / 2);
    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX    = 10'(SCREEN_H - 1);

    logic [9:0]         cur_x_q, cur_y_q;
    logic signed [10:0] nx, ny;

    // Candidate positions; an overflowed axis contributes no movement
    always_comb begin
        nx = $signed({1'b0, cur_x_q})
           + (pkt_q.x_ovf ? 11'sd0 : $signed({{2{pkt_q.dx[8]}}, pkt_q.dx}));
        // Screen Y grows downward while PS/2 up is positive
        ny = $signed({1'b0, cur_y_q})
           - (pkt_q.y_ovf ? 11'sd0 : $signed({{2{pkt_q.dy[8]}}, pkt_q.dy}));
    end

    // Cursor registers advance on the cycle pkt_valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q <= X_CENTER;
            cur_y_q <= Y_CENTER;
        end else if (pkt_valid_q) begin
            cur_x_q <= clamp_coord(nx, X_MAX);
            cur_y_q <= clamp_coord(ny, Y_MAX);
        end
    end

    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;
`endif

endmodule
